inst_fetch_unit: RTL and testbench

Parametrised program-counter and fetch-sequencing block, the next-generation replacement for the basic fetch unit. It adds a configurable PC width, signed conditional relative branches, a call/return address stack, per-program start addresses and an explicit run/halt state machine. It sits between the control decoder/ALU flags and the instruction ROM address port.

---
 rtl/inst_fetch_unit_if.sv | 38 +++
 rtl/inst_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit control/status bundle: master drives sequencing requests,
// slave (the fetch unit) returns the program counter and run/stack status.
interface inst_fetch_unit_if #(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
);
  localparam int LVL_W = $clog2(RAS_DEPTH + 1);

  logic              start_i;
  logic [PC_W-1:0]   start_addr_i;
  logic              stall_i;
  logic              halt_i;
  logic              branch_abs_i;
  logic              branch_rel_en_i;
  logic              alu_flag_i;
  logic              call_i;
  logic              ret_i;
  logic [PC_W-1:0]   target_i;
  logic [OFF_W-1:0]  offset_i;
  logic [PC_W-1:0]   prog_ctr_o;
  logic              running_o;
  logic              done_o;
  logic [LVL_W-1:0]  stack_lvl_o;
  logic              stack_err_o;

  modport master (
    output start_i, start_addr_i, stall_i, halt_i, branch_abs_i,
           branch_rel_en_i, alu_flag_i, call_i, ret_i, target_i, offset_i,
    input  prog_ctr_o, running_o, done_o, stack_lvl_o, stack_err_o
  );

  modport slave (
    input  start_i, start_addr_i, stall_i, halt_i, branch_abs_i,
           branch_rel_en_i, alu_flag_i, call_i, ret_i, target_i, offset_i,
    output prog_ctr_o, running_o, done_o, stack_lvl_o, stack_err_o
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Program counter and fetch sequencer with IDLE/RUN/HALT control.
// Define FETCH_RAS_EN to build the call/return address stack.
module inst_fetch_unit #(
  parameter int PC_W      = 10,
  parameter int OFF_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  inst_fetch_unit_if.slave  bus
);
  localparam int LVL_W = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        pc_inc_s, pc_rel_s, ras_top_s;
  logic [PC_W+OFF_W-1:0]  off_ext_s;
  logic                   call_s, ret_s, empty_s, full_s;
  logic                   push_s, pop_s, err_set_s, clear_s;

  assign off_ext_s = {{PC_W{bus.offset_i[OFF_W-1]}}, bus.offset_i};
  assign pc_inc_s  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_rel_s  = pc_q + off_ext_s[PC_W-1:0];

`ifdef FETCH_RAS_EN
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [LVL_W-1:0] lvl_q;
  logic             err_q;
  logic [IDX_W-1:0] top_idx_s, push_idx_s;

  assign call_s     = bus.call_i;
  assign ret_s      = bus.ret_i;
  assign empty_s    = (lvl_q == {LVL_W{1'b0}});
  assign full_s     = (lvl_q == LVL_W'(RAS_DEPTH));
  assign top_idx_s  = IDX_W'(lvl_q - {{(LVL_W-1){1'b0}}, 1'b1});
  assign push_idx_s = IDX_W'(lvl_q);
  assign ras_top_s  = ras_q[top_idx_s];

  // Return stack: cleared by Start, pushes return address on Call, pops on Ret
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_q <= {LVL_W{1'b0}};
      err_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {PC_W{1'b0}};
      end
    end else if (clear_s) begin
      lvl_q <= {LVL_W{1'b0}};
      err_q <= 1'b0;
    end else if (err_set_s) begin
      err_q <= 1'b1;
    end else if (push_s) begin
      ras_q[push_idx_s] <= pc_inc_s;
      lvl_q             <= lvl_q + {{(LVL_W-1){1'b0}}, 1'b1};
    end else if (pop_s) begin
      lvl_q <= lvl_q - {{(LVL_W-1){1'b0}}, 1'b1};
    end else begin
      lvl_q <= lvl_q;
    end
  end

  assign bus.stack_lvl_o = lvl_q;
  assign bus.stack_err_o = err_q;
`else
  logic unused_stack_s;

  assign call_s         = 1'b0;
  assign ret_s          = 1'b0;
  assign empty_s        = 1'b1;
  assign full_s         = 1'b1;
  assign ras_top_s      = {PC_W{1'b0}};
  assign unused_stack_s = ^{bus.call_i, bus.ret_i, push_s, pop_s, err_set_s, clear_s};

  assign bus.stack_lvl_o = {LVL_W{1'b0}};
  assign bus.stack_err_o = 1'b0;
`endif

  // State and program counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= {PC_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state and PC selection; one request wins per cycle, the rest are dropped
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    clear_s   = 1'b0;
    if (bus.start_i) begin
      pc_d    = bus.start_addr_i;
      state_d = ST_RUN;
      clear_s = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stall_i) begin
            pc_d = pc_q;
          end else if (bus.halt_i) begin
            state_d = ST_HALT;
          end else if (ret_s) begin
            if (empty_s) begin
              err_set_s = 1'b1;
              state_d   = ST_HALT;
            end else begin
              pc_d  = ras_top_s;
              pop_s = 1'b1;
            end
          end else if (call_s) begin
            if (full_s) begin
              err_set_s = 1'b1;
              state_d   = ST_HALT;
            end else begin
              pc_d   = bus.target_i;
              push_s = 1'b1;
            end
          end else if (bus.branch_abs_i) begin
            pc_d = bus.target_i;
          end else if (bus.branch_rel_en_i && bus.alu_flag_i) begin
            pc_d = pc_rel_s;
          end else begin
            pc_d = pc_inc_s;
          end
        end
        ST_IDLE, ST_HALT: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.prog_ctr_o = pc_q;
  assign bus.running_o  = (state_q == ST_RUN);
  assign bus.done_o     = (state_q == ST_HALT);
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Table-driven bench for inst_fetch_unit: each row is one cycle of requests plus
// the expected registered outputs, routed through a scoreboard queue.
module tb_inst_fetch_unit;
  localparam int PC_W = 10;
  localparam int OFF_W = 8;
  localparam int RAS_DEPTH = 4;
  localparam int LVL_W = $clog2(RAS_DEPTH + 1);

  typedef struct {
    string            nm;
    logic             st;
    logic [PC_W-1:0]  sa;
    logic             stl, hlt, ba, br, fl, ca, re;
    logic [PC_W-1:0]  tg;
    logic [OFF_W-1:0] of;
    logic [PC_W-1:0]  epc;
    logic             erun, edone;
    logic [LVL_W-1:0] elvl;
    logic             eerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  inst_fetch_unit_if #(.PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH)) bus ();

  inst_fetch_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic st, input logic [PC_W-1:0] sa,
                              input logic stl, input logic hlt, input logic ba, input logic br,
                              input logic fl, input logic ca, input logic re,
                              input logic [PC_W-1:0] tg, input logic [OFF_W-1:0] of,
                              input logic [PC_W-1:0] epc, input logic erun, input logic edone,
                              input logic [LVL_W-1:0] elvl, input logic eerr);
    vec_t v;
    v.nm = nm; v.st = st; v.sa = sa; v.stl = stl; v.hlt = hlt; v.ba = ba; v.br = br;
    v.fl = fl; v.ca = ca; v.re = re; v.tg = tg; v.of = of; v.epc = epc; v.erun = erun;
    v.edone = edone; v.elvl = elvl; v.eerr = eerr;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(input string nm, input logic [PC_W-1:0] epc, input logic erun,
                               input logic edone, input logic [LVL_W-1:0] elvl, input logic eerr);
    chk({nm, ".pc"},   32'(bus.prog_ctr_o),  32'(epc));
    chk({nm, ".run"},  32'(bus.running_o),   32'(erun));
    chk({nm, ".done"}, 32'(bus.done_o),      32'(edone));
    chk({nm, ".lvl"},  32'(bus.stack_lvl_o), 32'(elvl));
    chk({nm, ".err"},  32'(bus.stack_err_o), 32'(eerr));
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    bus.start_i = v.st; bus.start_addr_i = v.sa; bus.stall_i = v.stl; bus.halt_i = v.hlt;
    bus.branch_abs_i = v.ba; bus.branch_rel_en_i = v.br; bus.alu_flag_i = v.fl;
    bus.call_i = v.ca; bus.ret_i = v.re; bus.target_i = v.tg; bus.offset_i = v.of;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({v.nm, ".scoreboard"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_outputs(e.nm, e.epc, e.erun, e.edone, e.elvl, e.eerr);
    end
  endtask

  task automatic apply_idle_req(input string nm, input logic ba, input logic [PC_W-1:0] tg,
                                input logic [PC_W-1:0] epc, input logic erun);
    vec_t v;
    v.nm = nm; v.st = 1'b0; v.sa = 10'h000; v.stl = 1'b0; v.hlt = 1'b0; v.ba = ba;
    v.br = 1'b0; v.fl = 1'b0; v.ca = 1'b0; v.re = 1'b0; v.tg = tg; v.of = 8'h00;
    v.epc = epc; v.erun = erun; v.edone = 1'b0; v.elvl = 3'd0; v.eerr = 1'b0;
    apply(v);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.start_addr_i = 10'h000; bus.stall_i = 1'b0; bus.halt_i = 1'b0;
    bus.branch_abs_i = 1'b0; bus.branch_rel_en_i = 1'b0; bus.alu_flag_i = 1'b0;
    bus.call_i = 1'b0; bus.ret_i = 1'b0; bus.target_i = 10'h000; bus.offset_i = 8'h00;

    //   name         st  sa      stl   hlt   ba    br    fl    ca    re    tg      of     epc     run   done  lvl   err
    add("start_h1",   1'b1, 10'h040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h040, 1'b1, 1'b0, 3'd0, 1'b0);
    add("start_h2",   1'b1, 10'h040, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h040, 1'b1, 1'b0, 3'd0, 1'b0);
    add("adv1",       1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h041, 1'b1, 1'b0, 3'd0, 1'b0);
    add("adv2",       1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h042, 1'b1, 1'b0, 3'd0, 1'b0);
    add("st050",      1'b1, 10'h050, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h050, 1'b1, 1'b0, 3'd0, 1'b0);
    add("rel_neg",    1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 8'hFC, 10'h04C, 1'b1, 1'b0, 3'd0, 1'b0);
    add("st050b",     1'b1, 10'h050, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h050, 1'b1, 1'b0, 3'd0, 1'b0);
    add("rel_nflag",  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 8'hFC, 10'h051, 1'b1, 1'b0, 3'd0, 1'b0);
    add("st3ff",      1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h3FF, 1'b1, 1'b0, 3'd0, 1'b0);
    add("wrap",       1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h000, 1'b1, 1'b0, 3'd0, 1'b0);
    add("rel_pos",    1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 8'h7F, 10'h07F, 1'b1, 1'b0, 3'd0, 1'b0);
    add("rel_wrap",   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 8'h80, 10'h3FF, 1'b1, 1'b0, 3'd0, 1'b0);
    add("babs",       1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h123, 8'h00, 10'h123, 1'b1, 1'b0, 3'd0, 1'b0);
    add("stall_babs", 1'b0, 10'h000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h200, 8'h00, 10'h123, 1'b1, 1'b0, 3'd0, 1'b0);
    add("start_stall",1'b1, 10'h0AA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h0AA, 1'b1, 1'b0, 3'd0, 1'b0);
    add("halt",       1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h0AA, 1'b0, 1'b1, 3'd0, 1'b0);
    add("halt_hold",  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h0AA, 1'b0, 1'b1, 3'd0, 1'b0);
    add("halt_babs",  1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h300, 8'h00, 10'h0AA, 1'b0, 1'b1, 3'd0, 1'b0);
    add("restart",    1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h010, 1'b1, 1'b0, 3'd0, 1'b0);
`ifdef FETCH_RAS_EN
    add("call1",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h200, 8'h00, 10'h200, 1'b1, 1'b0, 3'd1, 1'b0);
    add("call2",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300, 8'h00, 10'h300, 1'b1, 1'b0, 3'd2, 1'b0);
    add("ret1",       1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 10'h201, 1'b1, 1'b0, 3'd1, 1'b0);
    add("ret2",       1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 10'h011, 1'b1, 1'b0, 3'd0, 1'b0);
    add("ret_under",  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 10'h011, 1'b0, 1'b1, 3'd0, 1'b1);
    add("err_hold",   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h011, 1'b0, 1'b1, 3'd0, 1'b1);
    add("restart_clr",1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h010, 1'b1, 1'b0, 3'd0, 1'b0);
    add("nest1",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 8'h00, 10'h100, 1'b1, 1'b0, 3'd1, 1'b0);
    add("nest2",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 8'h00, 10'h100, 1'b1, 1'b0, 3'd2, 1'b0);
    add("nest3",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 8'h00, 10'h100, 1'b1, 1'b0, 3'd3, 1'b0);
    add("nest4",      1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 8'h00, 10'h100, 1'b1, 1'b0, 3'd4, 1'b0);
    add("nest5_over", 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h150, 8'h00, 10'h100, 1'b0, 1'b1, 3'd4, 1'b1);
    add("restart2",   1'b1, 10'h020, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h020, 1'b1, 1'b0, 3'd0, 1'b0);
    add("call_a",     1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300, 8'h00, 10'h300, 1'b1, 1'b0, 3'd1, 1'b0);
    add("halt_call",  1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100, 8'h00, 10'h300, 1'b0, 1'b1, 3'd1, 1'b0);
    add("restart3",   1'b1, 10'h010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 8'h00, 10'h010, 1'b1, 1'b0, 3'd0, 1'b0);
    add("call_b",     1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h200, 8'h00, 10'h200, 1'b1, 1'b0, 3'd1, 1'b0);
    add("ret_call",   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h300, 8'h00, 10'h011, 1'b1, 1'b0, 3'd0, 1'b0);
`else
    add("call_ign",   1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h200, 8'h00, 10'h011, 1'b1, 1'b0, 3'd0, 1'b0);
    add("ret_ign",    1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000, 8'h00, 10'h012, 1'b1, 1'b0, 3'd0, 1'b0);
    add("ret_babs",   1'b0, 10'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1F0, 8'h00, 10'h1F0, 1'b1, 1'b0, 3'd0, 1'b0);
`endif

    #2;
    check_outputs("reset", 10'h000, 1'b0, 1'b0, 3'd0, 1'b0);
    #10;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle, checked before the next edge
    apply_idle_req("pre_rst", 1'b1, 10'h123, 10'h123, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 10'h000, 1'b0, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_idle_req("idle_hold", 1'b0, 10'h000, 10'h000, 1'b0);
    apply_idle_req("idle_babs", 1'b1, 10'h155, 10'h000, 1'b0);

    if (exp_q.size() != 0) begin
      chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
